seven_seg_scanner: RTL

//  Parametrised, time-multiplexed N-digit seven-segment driver; successor to the fixed 4-digit hex display.

---
 rtl/seven_seg_pkg.sv | 54 +++++
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/seven_seg_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, glyph table and elaboration helpers for the seven-segment scanner.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // Segment vectors are active-high here, ordered {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic logic [127:0] max_dec(input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < n; i++) p = p * 128'd10;
        return p - 128'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] bcd_out
);

    localparam int NDIG = DATA_W / 4;
    localparam int CW   = clog2(DATA_W);

    conv_state_e       state, state_nxt;
    logic [DATA_W-1:0] bin_sr, bcd_sr, bcd_adj;
    logic [CW-1:0]     cnt;
    logic              last;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    assign last = (state == SHIFT) && (cnt == CW'(DATA_W - 1));
    assign busy = (state == SHIFT);
    // Result is strobed on the final shift so the commit lands with the move to DONE.
    assign done    = last;
    assign bcd_out = {bcd_adj[DATA_W-2:0], bin_sr[DATA_W-1]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (start && state != SHIFT) begin
                bin_sr <= bin_in;
                bcd_sr <= '0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                {bcd_sr, bin_sr} <= {bcd_adj[DATA_W-2:0], bin_sr, 1'b0};
                cnt              <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with hex/decimal capture,
// leading-zero blanking, decimal points, overflow dashes and blank time.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] producto,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode_dec,
    input  logic                    lzb_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              LED_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    overflow
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int PW     = clog2(REFRESH_DIV);
    localparam logic [DATA_W-1:0] MAX_DEC = DATA_W'(max_dec(NUM_DIGITS));

    logic [DATA_W-1:0]            disp_reg;
    logic [NUM_DIGITS-1:0][3:0]   nib;
    logic [NUM_DIGITS-1:0]        zero_up;
    logic [PW-1:0]                prescaler;
    logic [IDX_W-1:0]             idx;
    logic                         accept, dec_ovf, conv_start, conv_busy, conv_done;
    logic [DATA_W-1:0]            conv_bcd;
    logic [6:0]                   seg_nxt;
    logic [NUM_DIGITS-1:0]        an_nxt;
    logic                         dp_nxt;

    // ---------------- capture / commit ----------------
    assign in_ready   = !conv_busy;
    assign accept     = in_valid && in_ready;
    assign dec_ovf    = (producto > MAX_DEC);
    assign conv_start = accept && mode_dec && !dec_ovf;

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start),
        .bin_in (producto),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd_out(conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_reg <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            disp_reg <= conv_bcd;
            overflow <= 1'b0;
        end else if (accept) begin
            if (!mode_dec) begin
                disp_reg <= producto;
                overflow <= 1'b0;
            end else if (dec_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- scan timing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PW'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // ---------------- glyph selection ----------------
    assign nib = disp_reg;

    // zero_up[i]: digit i and every digit above it are zero.
    always_comb begin
        logic z;
        zero_up = '0;
        z       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z          = z && (nib[i] == 4'd0);
            zero_up[i] = z;
        end
    end

    always_comb begin
        seg_nxt = seg_glyph(nib[idx]);
        if (overflow)
            seg_nxt = SEG_DASH;
        else if (lzb_en && idx != '0 && zero_up[idx])
            seg_nxt = SEG_BLANK;
        an_nxt = '0;
        if (prescaler >= PW'(BLANK_CYCLES)) an_nxt[idx] = 1'b1;
        dp_nxt = dp[idx];
    end

    // Polarity is applied at the output flops so internal logic stays active-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an      <= {NUM_DIGITS{ACTIVE_LOW}};
            LED_out <= {7{ACTIVE_LOW}};
            dp_out  <= ACTIVE_LOW;
        end else begin
            an      <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
            LED_out <= seg_nxt ^ {7{ACTIVE_LOW}};
            dp_out  <= dp_nxt ^ ACTIVE_LOW;
        end
    end

endmodule
